// File: rtl/alu_op_driver.sv
// Single-command ALU exerciser: launches operands, waits a settle window, captures the
// result and flags into a response channel, and optionally checks against an expected value.
module alu_op_driver #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic             cmd_chk,
  input  logic [31:0]      cmd_exp,
  output logic [3:0]       alu_op,
  output logic [31:0]      pa,
  output logic [31:0]      pb,
  input  logic [31:0]      presult,
  input  logic             neg,
  input  logic             ovf,
  input  logic             zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_neg,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic             rsp_mismatch,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_cnt
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gen_settle_range_chk
    $error("alu_op_driver: SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic             chk_q, chk_d;
  logic [31:0]      exp_q, exp_d;
  logic [3:0]       alu_op_d;
  logic [31:0]      pa_d, pb_d;
  logic [31:0]      rsp_result_d;
  logic             rsp_neg_d, rsp_ovf_d, rsp_zero_d, rsp_mismatch_d;
  logic [CNT_W-1:0] issue_cnt_d, err_cnt_d;

  logic cmd_hs;
  logic capture;
  logic mismatch_now;

  assign cmd_ready    = (state_q == StIdle) && nRST;
  assign rsp_valid    = (state_q == StResp);
  assign cmd_hs       = cmd_valid && cmd_ready;
  assign capture      = (state_q == StSettle) && (settle_q == 4'd0);
  assign mismatch_now = chk_q && (presult != exp_q);

  always_comb begin
    state_d        = state_q;
    settle_d       = settle_q;
    chk_d          = chk_q;
    exp_d          = exp_q;
    alu_op_d       = alu_op;
    pa_d           = pa;
    pb_d           = pb;
    rsp_result_d   = rsp_result;
    rsp_neg_d      = rsp_neg;
    rsp_ovf_d      = rsp_ovf;
    rsp_zero_d     = rsp_zero;
    rsp_mismatch_d = rsp_mismatch;

    case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          alu_op_d = cmd_op;
          pa_d     = cmd_a;
          pb_d     = cmd_b;
          chk_d    = cmd_chk;
          exp_d    = cmd_exp;
          // Operand registers update on the accept edge, so the window counts from the
          // following cycle: capture lands SETTLE_CYCLES+1 edges after accept.
          settle_d = 4'(SETTLE_CYCLES);
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (capture) begin
          rsp_result_d   = presult;
          rsp_neg_d      = neg;
          rsp_ovf_d      = ovf;
          rsp_zero_d     = zero;
          rsp_mismatch_d = mismatch_now;
          state_d        = StResp;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear beats a coincident increment; counters stick at all-ones.
  always_comb begin
    issue_cnt_d = issue_cnt;
    err_cnt_d   = err_cnt;
    if (clr_cnt) begin
      issue_cnt_d = '0;
      err_cnt_d   = '0;
    end else if (capture) begin
      if (issue_cnt != CntMax) begin
        issue_cnt_d = issue_cnt + CNT_W'(1);
      end
      if (mismatch_now && (err_cnt != CntMax)) begin
        err_cnt_d = err_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= StIdle;
      settle_q     <= 4'd0;
      chk_q        <= 1'b0;
      exp_q        <= '0;
      alu_op       <= '0;
      pa           <= '0;
      pb           <= '0;
      rsp_result   <= '0;
      rsp_neg      <= 1'b0;
      rsp_ovf      <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_mismatch <= 1'b0;
      issue_cnt    <= '0;
      err_cnt      <= '0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      chk_q        <= chk_d;
      exp_q        <= exp_d;
      alu_op       <= alu_op_d;
      pa           <= pa_d;
      pb           <= pb_d;
      rsp_result   <= rsp_result_d;
      rsp_neg      <= rsp_neg_d;
      rsp_ovf      <= rsp_ovf_d;
      rsp_zero     <= rsp_zero_d;
      rsp_mismatch <= rsp_mismatch_d;
      issue_cnt    <= issue_cnt_d;
      err_cnt      <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// Directed bench for alu_op_driver: instance a (SETTLE_CYCLES=1, CNT_W=16) and
// instance b (SETTLE_CYCLES=3, CNT_W=2), each driving a small adder model as its ALU.
module tb_alu_op_driver;

  logic clk;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a signals
  logic        a_nrst, a_cmd_valid, a_cmd_ready, a_cmd_chk, a_rsp_valid, a_rsp_ready, a_clr;
  logic [3:0]  a_cmd_op, a_alu_op;
  logic [31:0] a_cmd_a, a_cmd_b, a_cmd_exp, a_pa, a_pb, a_presult, a_rsp_result, a_noise;
  logic        a_neg, a_ovf, a_zero, a_rsp_neg, a_rsp_ovf, a_rsp_zero, a_rsp_mismatch;
  logic [15:0] a_issue, a_err;

  // Instance b signals
  logic        b_nrst, b_cmd_valid, b_cmd_ready, b_cmd_chk, b_rsp_valid, b_rsp_ready, b_clr;
  logic [3:0]  b_cmd_op, b_alu_op;
  logic [31:0] b_cmd_a, b_cmd_b, b_cmd_exp, b_pa, b_pb, b_presult, b_rsp_result;
  logic        b_neg, b_ovf, b_zero, b_rsp_neg, b_rsp_ovf, b_rsp_zero, b_rsp_mismatch;
  logic [1:0]  b_issue, b_err;

  // Adder ALU models; a_noise perturbs a's output to prove the response is held.
  always_comb begin
    a_presult = a_pa + a_pb + a_noise;
    a_neg     = a_presult[31];
    a_ovf     = (a_pa[31] == a_pb[31]) && (a_presult[31] != a_pa[31]);
    a_zero    = (a_presult == 32'd0);
    b_presult = b_pa + b_pb;
    b_neg     = b_presult[31];
    b_ovf     = (b_pa[31] == b_pb[31]) && (b_presult[31] != b_pa[31]);
    b_zero    = (b_presult == 32'd0);
  end

  alu_op_driver #(.SETTLE_CYCLES(1), .CNT_W(16)) u_dut_a (
    .CLK(clk), .nRST(a_nrst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_op(a_cmd_op), .cmd_a(a_cmd_a), .cmd_b(a_cmd_b), .cmd_chk(a_cmd_chk),
    .cmd_exp(a_cmd_exp), .alu_op(a_alu_op), .pa(a_pa), .pb(a_pb), .presult(a_presult),
    .neg(a_neg), .ovf(a_ovf), .zero(a_zero), .rsp_valid(a_rsp_valid),
    .rsp_ready(a_rsp_ready), .rsp_result(a_rsp_result), .rsp_neg(a_rsp_neg),
    .rsp_ovf(a_rsp_ovf), .rsp_zero(a_rsp_zero), .rsp_mismatch(a_rsp_mismatch),
    .issue_cnt(a_issue), .err_cnt(a_err), .clr_cnt(a_clr)
  );

  alu_op_driver #(.SETTLE_CYCLES(3), .CNT_W(2)) u_dut_b (
    .CLK(clk), .nRST(b_nrst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_op(b_cmd_op), .cmd_a(b_cmd_a), .cmd_b(b_cmd_b), .cmd_chk(b_cmd_chk),
    .cmd_exp(b_cmd_exp), .alu_op(b_alu_op), .pa(b_pa), .pb(b_pb), .presult(b_presult),
    .neg(b_neg), .ovf(b_ovf), .zero(b_zero), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_result(b_rsp_result), .rsp_neg(b_rsp_neg),
    .rsp_ovf(b_rsp_ovf), .rsp_zero(b_rsp_zero), .rsp_mismatch(b_rsp_mismatch),
    .issue_cnt(b_issue), .err_cnt(b_err), .clr_cnt(b_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge; returns just after the accepting edge.
  task automatic a_cmd(input logic [31:0] a, input logic [31:0] b, input logic chk,
                       input logic [31:0] exp);
    a_cmd_valid = 1'b1; a_cmd_op = 4'h1; a_cmd_a = a; a_cmd_b = b;
    a_cmd_chk = chk; a_cmd_exp = exp;
    tick();
    a_cmd_valid = 1'b0;
  endtask

  task automatic b_cmd(input logic [31:0] a, input logic [31:0] b, input logic chk,
                       input logic [31:0] exp);
    b_cmd_valid = 1'b1; b_cmd_op = 4'h2; b_cmd_a = a; b_cmd_b = b;
    b_cmd_chk = chk; b_cmd_exp = exp;
    tick();
    b_cmd_valid = 1'b0;
  endtask

  task automatic b_wait_rsp(input string tag);
    for (int i = 0; i < 12 && !b_rsp_valid; i++) tick();
    check_eq(tag, {31'd0, b_rsp_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    a_nrst = 0; a_cmd_valid = 0; a_cmd_op = 0; a_cmd_a = 0; a_cmd_b = 0; a_cmd_chk = 0;
    a_cmd_exp = 0; a_rsp_ready = 0; a_clr = 0; a_noise = 0;
    b_nrst = 0; b_cmd_valid = 0; b_cmd_op = 0; b_cmd_a = 0; b_cmd_b = 0; b_cmd_chk = 0;
    b_cmd_exp = 0; b_rsp_ready = 0; b_clr = 0;

    // Reset then idle
    tick(); tick();
    a_nrst = 1; b_nrst = 1;
    #1;
    check_eq("rst_cmd_ready", {31'd0, a_cmd_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check_eq("rst_pa", a_pa, 32'd0);
    check_eq("rst_pb", a_pb, 32'd0);
    check_eq("rst_issue", {16'd0, a_issue}, 32'd0);
    tick();

    // Passing check, 5+7=12
    a_cmd(32'd5, 32'd7, 1'b1, 32'd12);
    check_eq("pass_pa", a_pa, 32'd5);
    check_eq("pass_pb", a_pb, 32'd7);
    check_eq("pass_valid_n1", {31'd0, a_rsp_valid}, 32'd0);
    check_eq("pass_cmd_ready_busy", {31'd0, a_cmd_ready}, 32'd0);
    tick();
    check_eq("pass_valid_n2_early", {31'd0, a_rsp_valid}, 32'd0);
    tick();
    check_eq("pass_valid_n2", {31'd0, a_rsp_valid}, 32'd1);
    check_eq("pass_result", a_rsp_result, 32'd12);
    check_eq("pass_mismatch", {31'd0, a_rsp_mismatch}, 32'd0);
    check_eq("pass_issue", {16'd0, a_issue}, 32'd1);
    check_eq("pass_err", {16'd0, a_err}, 32'd0);
    a_rsp_ready = 1; tick(); a_rsp_ready = 0;
    check_eq("pass_cmd_ready_after", {31'd0, a_cmd_ready}, 32'd1);

    // Overflowing add against a wrong expectation
    a_cmd(32'h7FFF_FFFF, 32'd1, 1'b1, 32'd0);
    tick(); tick();
    check_eq("ovf_valid", {31'd0, a_rsp_valid}, 32'd1);
    check_eq("ovf_result", a_rsp_result, 32'h8000_0000);
    check_eq("ovf_neg", {31'd0, a_rsp_neg}, 32'd1);
    check_eq("ovf_ovf", {31'd0, a_rsp_ovf}, 32'd1);
    check_eq("ovf_zero", {31'd0, a_rsp_zero}, 32'd0);
    check_eq("ovf_mismatch", {31'd0, a_rsp_mismatch}, 32'd1);
    check_eq("ovf_err", {16'd0, a_err}, 32'd1);
    check_eq("ovf_issue", {16'd0, a_issue}, 32'd2);

    // Backpressure: model output moves, response must not
    for (int i = 0; i < 5; i++) begin
      a_noise = 32'(i + 1);
      tick();
      check_eq("bp_result", a_rsp_result, 32'h8000_0000);
      check_eq("bp_mismatch", {31'd0, a_rsp_mismatch}, 32'd1);
      check_eq("bp_valid", {31'd0, a_rsp_valid}, 32'd1);
      check_eq("bp_cmd_ready", {31'd0, a_cmd_ready}, 32'd0);
    end
    a_rsp_ready = 1; tick(); a_rsp_ready = 0; a_noise = 0;
    check_eq("bp_cmd_ready_after", {31'd0, a_cmd_ready}, 32'd1);
    check_eq("bp_valid_after", {31'd0, a_rsp_valid}, 32'd0);

    // chk=0 never flags a mismatch; 3 + -3 = 0 sets zero
    a_cmd(32'd3, 32'hFFFF_FFFD, 1'b0, 32'd5);
    tick(); tick();
    check_eq("nochk_result", a_rsp_result, 32'd0);
    check_eq("nochk_zero", {31'd0, a_rsp_zero}, 32'd1);
    check_eq("nochk_mismatch", {31'd0, a_rsp_mismatch}, 32'd0);
    check_eq("nochk_err", {16'd0, a_err}, 32'd1);
    check_eq("nochk_issue", {16'd0, a_issue}, 32'd3);
    a_rsp_ready = 1; tick(); a_rsp_ready = 0;

    // SETTLE_CYCLES=3: response exactly at edge N+4
    b_cmd(32'd1, 32'd2, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("s3_valid_early", {31'd0, b_rsp_valid}, 32'd0);
    end
    tick();
    check_eq("s3_valid_n4", {31'd0, b_rsp_valid}, 32'd1);
    check_eq("s3_result", b_rsp_result, 32'd3);
    check_eq("s3_issue", {30'd0, b_issue}, 32'd1);
    b_rsp_ready = 1; tick(); b_rsp_ready = 0;

    // Reset while settling aborts the command
    b_cmd(32'd4, 32'd4, 1'b1, 32'd9);
    tick();
    b_nrst = 0;
    tick();
    check_eq("abort_valid", {31'd0, b_rsp_valid}, 32'd0);
    check_eq("abort_issue", {30'd0, b_issue}, 32'd0);
    check_eq("abort_err", {30'd0, b_err}, 32'd0);
    check_eq("abort_pa", b_pa, 32'd0);
    check_eq("abort_cmd_ready_in_rst", {31'd0, b_cmd_ready}, 32'd0);
    b_nrst = 1;
    #1;
    check_eq("abort_cmd_ready", {31'd0, b_cmd_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("abort_no_rsp", {31'd0, b_rsp_valid}, 32'd0);
    end
    check_eq("abort_idle", {31'd0, b_cmd_ready}, 32'd1);

    // Five failing checks saturate the 2-bit counters at 3
    for (int i = 0; i < 5; i++) begin
      b_cmd(32'(i), 32'd1, 1'b1, 32'd0);
      b_wait_rsp("sat_wait");
      check_eq("sat_mismatch", {31'd0, b_rsp_mismatch}, 32'd1);
      b_rsp_ready = 1; tick(); b_rsp_ready = 0;
    end
    check_eq("sat_issue", {30'd0, b_issue}, 32'd3);
    check_eq("sat_err", {30'd0, b_err}, 32'd3);

    // Clear coinciding with a capture wins
    b_cmd(32'd10, 32'd1, 1'b1, 32'd0);
    tick(); tick(); tick();
    check_eq("clr_pre_valid", {31'd0, b_rsp_valid}, 32'd0);
    b_clr = 1;
    tick();
    b_clr = 0;
    check_eq("clr_valid", {31'd0, b_rsp_valid}, 32'd1);
    check_eq("clr_mismatch", {31'd0, b_rsp_mismatch}, 32'd1);
    check_eq("clr_issue", {30'd0, b_issue}, 32'd0);
    check_eq("clr_err", {30'd0, b_err}, 32'd0);
    b_rsp_ready = 1; tick(); b_rsp_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
